// File: rtl/led_nios2_processor_oci_dct_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : led_nios2_processor_oci_dct_packer                             |
// | Purpose : Producer side of the OCI debug-capture-trace frame interface.  |
// |           Packs 2-bit trace items LSB-first into a 30-bit frame and      |
// |           presents full or flushed frames over a valid/ready handshake.  |
// |           Also drives the test_ending / test_has_ended session status.   |
// | Ports   : clk_i, reset_i (async, active-high)                            |
// |           item_valid_i/item_data_i/item_ready_o : trace item input       |
// |           flush_i        : emit the partial frame                        |
// |           test_end_req_i : close the trace session                       |
// |           dct_buffer_o/dct_count_o/dct_valid_o/dct_ready_i : frame out   |
// |           test_ending_o/test_has_ended_o : session status                |
// |           frame_count_o  : handshake counter (OCI_DCT_FRAME_CNT_EN only) |
// | Options : define OCI_DCT_FRAME_CNT_EN to add frame_count_o               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module led_nios2_processor_oci_dct_packer #(
  parameter int MAX_COUNT     = 15,  // items per full frame, 1..15
  parameter int FLUSH_TIMEOUT = 64   // idle cycles before auto flush, 0 = off
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        item_valid_i,
  input  logic [1:0]  item_data_i,
  output logic        item_ready_o,
  input  logic        flush_i,
  input  logic        test_end_req_i,
  output logic [29:0] dct_buffer_o,
  output logic [3:0]  dct_count_o,
  output logic        dct_valid_o,
  input  logic        dct_ready_i,
  output logic        test_ending_o,
  output logic        test_has_ended_o
`ifdef OCI_DCT_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count_o
`endif
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_ENDED = 2'd2
  } state_t;

  // Timer is wide enough to hold FLUSH_TIMEOUT itself.
  localparam int            TW         = $clog2(FLUSH_TIMEOUT + 2);
  localparam bit            TIMER_EN   = (FLUSH_TIMEOUT > 0);
  localparam logic [TW-1:0] TIMER_LAST = TIMER_EN ? TW'(FLUSH_TIMEOUT - 1) : '0;
  localparam logic [3:0]    FULL_CNT   = 4'(MAX_COUNT);

  state_t        state_q, state_d;
  logic [29:0]   buffer_q, buffer_d;
  logic [3:0]    count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ready_q, ready_d;
  logic          valid_q, valid_d;
  logic          ending_q, ending_d;
  logic          ended_q, ended_d;
  logic          accept;
  logic          timeout_hit;
  logic          flush_req;

  always_comb begin
    state_d     = state_q;
    buffer_d    = buffer_q;
    count_d     = count_q;
    timer_d     = timer_q;
    ending_d    = ending_q | test_end_req_i;
    accept      = item_valid_i & ready_q;
    timeout_hit = 1'b0;
    flush_req   = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          // Only slots below MAX_COUNT are ever written, so the upper
          // buffer bits stay zero for short frames.
          for (int k = 0; k < 15; k++) begin
            if ((k < MAX_COUNT) && (count_q == 4'(k))) begin
              buffer_d[2*k +: 2] = item_data_i;
            end
          end
          count_d = count_q + 4'd1;
          timer_d = '0;
        end else if (TIMER_EN && (count_q != 4'd0)) begin
          timer_d     = timer_q + 1'b1;
          // This idle cycle is the FLUSH_TIMEOUT-th one.
          timeout_hit = (timer_q == TIMER_LAST);
        end

        flush_req = flush_i | timeout_hit;

        // Decisions use the count after this cycle's item is included.
        if (count_d == FULL_CNT) begin
          state_d = ST_EMIT;
        end else if (test_end_req_i) begin
          state_d = (count_d != 4'd0) ? ST_EMIT : ST_ENDED;
        end else if (flush_req && (count_d != 4'd0)) begin
          state_d = ST_EMIT;
        end
      end

      ST_EMIT: begin
        if (dct_ready_i) begin
          buffer_d = '0;
          count_d  = 4'd0;
          timer_d  = '0;
          state_d  = ending_d ? ST_ENDED : ST_FILL;
        end
      end

      ST_ENDED: begin
        state_d = ST_ENDED;
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase

    ready_d = (state_d == ST_FILL) && !ending_d;
    valid_d = (state_d == ST_EMIT);
    ended_d = (state_d == ST_ENDED);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_FILL;
      buffer_q <= '0;
      count_q  <= 4'd0;
      timer_q  <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      ending_q <= 1'b0;
      ended_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buffer_q <= buffer_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      ending_q <= ending_d;
      ended_q  <= ended_d;
    end
  end

  assign item_ready_o     = ready_q;
  assign dct_buffer_o     = buffer_q;
  assign dct_count_o      = count_q;
  assign dct_valid_o      = valid_q;
  assign test_ending_o    = ending_q;
  assign test_has_ended_o = ended_q;

`ifdef OCI_DCT_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Saturating count of completed frame handshakes.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      frame_cnt_q <= 16'd0;
    end else if (valid_q && dct_ready_i && (frame_cnt_q != 16'hFFFF)) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_count_o = frame_cnt_q;
`endif

endmodule
`default_nettype wire
